peak_dpu_lsu: RTL

//  Load/store execution unit downstream of the ld/st decoder. Accepts one decoded

---
 rtl/peak_dpu_lsu.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/peak_dpu_lsu.sv
// peak_dpu_lsu: load/store unit, single-outstanding req/gnt/rvalid bus.
// Forms the EA, aligns lanes and reports misalign, bus errors and timeouts.
module peak_dpu_lsu #(
    parameter int unsigned TMO_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_vld,
    output logic        ex_rdy,
    input  logic [2:0]  ex_ls_op,
    input  logic [31:0] ex_base,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_sdata,
    input  logic [4:0]  ex_wr_addr,
    output logic        dbus_req,
    output logic [31:0] dbus_addr,
    output logic        dbus_we,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_err,
    output logic        wb_vld,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        lsu_misalign,
    output logic        lsu_bus_err,
    output logic [31:0] lsu_exc_addr
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    // Last counter value before the cycle budget is exhausted.
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  cnt_q;
    logic [31:0] ea;
    logic        accept;
    logic        mis;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        tmo;
    logic        resp_ok;
    logic        resp_err;

    logic [31:0] ea_q;
    logic [2:0]  op_q;
    logic [4:0]  wr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        is_load_q;
    logic [31:0] shifted;
    logic [31:0] ld_data;

    assign ea     = ex_base + ex_imm;
    assign ex_rdy = (state_q == IDLE);
    assign accept = ex_vld & ex_rdy;

    assign dbus_req   = (state_q == REQ);
    assign dbus_addr  = {ea_q[31:2], 2'b00};
    assign dbus_we    = ~is_load_q & (op_q != 3'd0 | 1'b0) & (op_q >= OP_SB);
    assign dbus_be    = be_q;
    assign dbus_wdata = wdata_q;

    assign is_load_q = (op_q < OP_SB);

    // Alignment check and store lane steering for the incoming access.
    always_comb begin
        mis     = 1'b0;
        be_d    = 4'b1111;
        wdata_d = ex_sdata;
        unique case (ex_ls_op)
            OP_LH, OP_LHU: mis = ea[0];
            OP_LW:         mis = |ea[1:0];
            OP_SB: begin
                be_d    = 4'b0001 << ea[1:0];
                wdata_d = {4{ex_sdata[7:0]}};
            end
            OP_SH: begin
                mis     = ea[0];
                be_d    = ea[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{ex_sdata[15:0]}};
            end
            OP_SW:         mis = |ea[1:0];
            default:       mis = 1'b0;
        endcase
    end

    // Next-state logic, timeout detection and response classification.
    always_comb begin
        state_d  = state_q;
        tmo      = 1'b0;
        resp_ok  = 1'b0;
        resp_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && !mis) state_d = REQ;
            end
            REQ: begin
                if (dbus_gnt) begin
                    state_d = RESP;
                end else if (cnt_q == TMO_LAST) begin
                    tmo     = 1'b1;
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (dbus_rvalid) begin
                    resp_err = dbus_err;
                    resp_ok  = ~dbus_err;
                    state_d  = IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    tmo     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift the addressed lane down, then sign or zero extend.
    always_comb begin
        shifted = dbus_rdata >> {ea_q[1:0], 3'b000};
        ld_data = shifted;
        unique case (op_q)
            OP_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LH:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LBU:  ld_data = {24'd0, shifted[7:0]};
            OP_LHU:  ld_data = {16'd0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    // State register and per-state cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) cnt_q <= 8'd0;
            else if (state_q != IDLE) cnt_q <= cnt_q + 8'd1;
        end
    end

    // Capture the accepted access; held stable for the whole transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ea_q    <= 32'd0;
            op_q    <= 3'd0;
            wr_q    <= 5'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            ea_q    <= ea;
            op_q    <= ex_ls_op;
            wr_q    <= ex_wr_addr;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    // Registered write-back and exception pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_vld       <= 1'b0;
            wb_addr      <= 5'd0;
            wb_data      <= 32'd0;
            lsu_misalign <= 1'b0;
            lsu_bus_err  <= 1'b0;
            lsu_exc_addr <= 32'd0;
        end else begin
            wb_vld       <= resp_ok & is_load_q;
            lsu_misalign <= accept & mis;
            lsu_bus_err  <= tmo | resp_err;
            if (resp_ok && is_load_q) begin
                wb_addr <= wr_q;
                wb_data <= ld_data;
            end
            if (accept && mis) lsu_exc_addr <= ea;
            else if (tmo || resp_err) lsu_exc_addr <= ea_q;
        end
    end

endmodule
